// File: rtl/bath_mode_ctrl.sv
// Bath heater power-up and N-mode one-hot controller on the 1 kHz tick.
// Handles warm-up lockout, per-mode cool-down, auto-off run timeout and cool-down abort.
module bath_mode_ctrl #(
  parameter int                         N_MODES     = 4,
  parameter int                         DLY_W       = 16,
  parameter logic [N_MODES*DLY_W-1:0]   OFF_DLY     = {16'd0, 16'd4000, 16'd2000, 16'd0},
  parameter int                         WARMUP_MS   = 2000,
  parameter int                         AUTO_W      = 22,
  parameter int                         AUTO_OFF_MS = 0
) (
  input  logic               clk_1kHz,
  input  logic               rst,
  input  logic               main_sw,
  input  logic [N_MODES-1:0] btn_pulse,
  output logic [1:0]         on_st,
  output logic [N_MODES-1:0] mode,
  output logic               cooling,
  output logic [DLY_W-1:0]   remain_ms,
  output logic [AUTO_W-1:0]  run_ms
);

  localparam int                 WARM_W    = (WARMUP_MS > 1) ? $clog2(WARMUP_MS) : 1;
  localparam logic [WARM_W-1:0]  WARM_LAST = WARM_W'(WARMUP_MS - 1);
  localparam logic [AUTO_W-1:0]  AUTO_LAST = AUTO_W'(AUTO_OFF_MS - 1);

  typedef enum logic [1:0] {P_OFF = 2'b00, P_WARM = 2'b01, P_READY = 2'b10} pwr_e;
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_COOL} mst_e;

  pwr_e               pwr_q,    pwr_d;
  mst_e               mst_q,    mst_d;
  logic [WARM_W-1:0]  warm_q,   warm_d;
  logic [N_MODES-1:0] mode_q,   mode_d;
  logic               cool_q,   cool_d;
  logic [DLY_W-1:0]   remain_q, remain_d;
  logic [AUTO_W-1:0]  run_q,    run_d;

  // Cool-down delay of the active mode: mask each slice by its one-hot bit, then OR.
  logic [N_MODES-1:0][DLY_W-1:0] dly_mask;
  logic [DLY_W-1:0]              cur_dly;

  for (genvar g = 0; g < N_MODES; g++) begin : g_dly
    assign dly_mask[g] = mode_q[g] ? OFF_DLY[g*DLY_W +: DLY_W] : '0;
  end

  always_comb begin
    cur_dly = '0;
    for (int i = 0; i < N_MODES; i++) cur_dly = cur_dly | dly_mask[i];
  end

  logic btn_ok, btn_other, btn_same, auto_hit;
  logic [AUTO_W-1:0] run_inc;

  assign btn_ok    = (btn_pulse != '0) && ((btn_pulse & (btn_pulse - N_MODES'(1))) == '0);
  assign btn_other = btn_ok && (btn_pulse != mode_q);
  assign btn_same  = btn_ok && (btn_pulse == mode_q);
  assign auto_hit  = (AUTO_OFF_MS != 0) && (run_q == AUTO_LAST);
  assign run_inc   = (&run_q) ? run_q : run_q + AUTO_W'(1);

  always_comb begin
    pwr_d    = pwr_q;
    mst_d    = mst_q;
    warm_d   = warm_q;
    mode_d   = mode_q;
    cool_d   = cool_q;
    remain_d = remain_q;
    run_d    = run_q;
    if (!main_sw) begin
      pwr_d    = P_OFF;
      mst_d    = M_IDLE;
      warm_d   = '0;
      mode_d   = '0;
      cool_d   = 1'b0;
      remain_d = '0;
      run_d    = '0;
    end else begin
      case (pwr_q)
        P_OFF: begin
          pwr_d  = P_WARM;
          warm_d = '0;
        end
        P_WARM: begin
          if (warm_q == WARM_LAST) pwr_d = P_READY;
          else                     warm_d = warm_q + WARM_W'(1);
        end
        P_READY: begin
          case (mst_q)
            M_IDLE: begin
              if (btn_ok) begin
                mst_d  = M_RUN;
                mode_d = btn_pulse;
                run_d  = '0;
              end
            end
            M_RUN: begin
              // A valid button outranks the auto-off timeout on the same edge.
              if (btn_other) begin
                mode_d = btn_pulse;
                run_d  = '0;
              end else if (btn_same || auto_hit) begin
                run_d = '0;
                if (cur_dly == '0) begin
                  mst_d  = M_IDLE;
                  mode_d = '0;
                end else begin
                  mst_d    = M_COOL;
                  cool_d   = 1'b1;
                  remain_d = cur_dly;
                end
              end else begin
                run_d = run_inc;
              end
            end
            M_COOL: begin
              if (btn_other) begin
                mst_d    = M_RUN;
                mode_d   = btn_pulse;
                cool_d   = 1'b0;
                remain_d = '0;
                run_d    = '0;
              end else if (remain_q <= DLY_W'(1)) begin
                mst_d    = M_IDLE;
                mode_d   = '0;
                cool_d   = 1'b0;
                remain_d = '0;
              end else begin
                remain_d = remain_q - DLY_W'(1);
              end
            end
            default: mst_d = M_IDLE;
          endcase
        end
        default: pwr_d = P_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      pwr_q    <= P_OFF;
      mst_q    <= M_IDLE;
      warm_q   <= '0;
      mode_q   <= '0;
      cool_q   <= 1'b0;
      remain_q <= '0;
      run_q    <= '0;
    end else begin
      pwr_q    <= pwr_d;
      mst_q    <= mst_d;
      warm_q   <= warm_d;
      mode_q   <= mode_d;
      cool_q   <= cool_d;
      remain_q <= remain_d;
      run_q    <= run_d;
    end
  end

  assign on_st     = pwr_q;
  assign mode      = mode_q;
  assign cooling   = cool_q;
  assign remain_ms = remain_q;
  assign run_ms    = run_q;

endmodule

// File: tb/tb_bath_mode_ctrl.sv
// Directed + randomized bench for bath_mode_ctrl against a cycle-level behavioural model.
module tb_bath_mode_ctrl;
  localparam int NM = 4, DW = 16, AW = 22, WU = 2000, AO = 50;

  logic          clk_1kHz = 1'b0;
  logic          rst = 1'b1;
  logic          main_sw = 1'b0;
  logic [NM-1:0] btn_pulse = '0;
  logic [1:0]    on_st;
  logic [NM-1:0] mode;
  logic          cooling;
  logic [DW-1:0] remain_ms;
  logic [AW-1:0] run_ms;

  bath_mode_ctrl #(
    .N_MODES(NM), .DLY_W(DW), .OFF_DLY({16'd0, 16'd4000, 16'd2000, 16'd0}),
    .WARMUP_MS(WU), .AUTO_W(AW), .AUTO_OFF_MS(AO)
  ) dut (
    .clk_1kHz(clk_1kHz), .rst(rst), .main_sw(main_sw), .btn_pulse(btn_pulse),
    .on_st(on_st), .mode(mode), .cooling(cooling), .remain_ms(remain_ms), .run_ms(run_ms)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  int total = 0, bad = 0;

  // Model: power level 0/1/2, warm cycles left, active mode index (-1 none),
  // cool-down ms left (0 = not cooling), run ms.
  int m_on, m_wleft, m_mode, m_cool, m_run;
  int dly_tab [4] = '{0, 2000, 4000, 0};

  function automatic void m_reset();
    m_on = 0; m_wleft = 0; m_mode = -1; m_cool = 0; m_run = 0;
  endfunction

  function automatic void m_step(input logic sw, input logic [NM-1:0] b);
    int j;
    bit ok, off_req;
    if (!sw) begin m_reset(); return; end
    if (m_on == 0) begin m_on = 1; m_wleft = WU - 1; return; end
    if (m_on == 1) begin
      if (m_wleft == 0) m_on = 2; else m_wleft--;
      return;
    end
    ok = ($countones(b) == 1);
    j = -1;
    for (int k = 0; k < NM; k++) if (b[k]) j = k;
    if (m_mode < 0) begin
      if (ok) begin m_mode = j; m_run = 0; end
    end else if (m_cool > 0) begin
      if (ok && j != m_mode) begin m_mode = j; m_cool = 0; m_run = 0; end
      else if (m_cool == 1) begin m_mode = -1; m_cool = 0; end
      else m_cool--;
    end else begin
      off_req = (ok && j == m_mode) || (AO != 0 && m_run == AO - 1);
      if (ok && j != m_mode) begin m_mode = j; m_run = 0; end
      else if (off_req) begin
        m_run = 0;
        if (dly_tab[m_mode] == 0) m_mode = -1;
        else m_cool = dly_tab[m_mode];
      end else if (m_run < (1 << AW) - 1) m_run++;
    end
  endfunction

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
    if (bad > 20) finish_run();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".on_st"},   64'(on_st),     64'(m_on));
    chk({tag, ".mode"},    64'(mode),      (m_mode < 0) ? 64'd0 : (64'd1 << m_mode));
    chk({tag, ".cooling"}, 64'(cooling),   64'(m_cool > 0));
    chk({tag, ".remain"},  64'(remain_ms), 64'(m_cool));
    chk({tag, ".run"},     64'(run_ms),    64'(m_run));
  endtask

  task automatic tick(input logic sw, input logic [NM-1:0] b);
    @(negedge clk_1kHz);
    main_sw   = sw;
    btn_pulse = b;
    @(posedge clk_1kHz);
    if (rst) m_reset(); else m_step(sw, b);
    #1;
    chk_model("cyc");
  endtask

  initial begin
    logic [NM-1:0] rb;
    int r;
    m_reset();
    // Reset, then release with the master switch off.
    tick(1'b0, '0); tick(1'b0, '0);
    @(negedge clk_1kHz); rst = 1'b0;
    repeat (3) tick(1'b0, '0);
    chk("rst_on", 64'(on_st), 64'd0);

    // Warm-up: 2000 cycles of 01, button ignored mid-way.
    for (int i = 0; i < WU; i++) begin
      tick(1'b1, (i == 1000) ? 4'b0010 : 4'b0000);
      if (i == 0 || i == WU - 1) chk("warm_on", 64'(on_st), 64'd1);
    end
    tick(1'b1, '0);
    chk("ready_on", 64'(on_st), 64'd2);
    chk("warm_btn_ignored", 64'(mode), 64'd0);

    // Mode 0 on / immediate off / multi-bit ignored.
    tick(1'b1, 4'b0001); chk("m0_on", 64'(mode), 64'b0001);
    tick(1'b1, 4'b0001); chk("m0_off", 64'(mode), 64'd0);
    chk("m0_nocool", 64'(cooling), 64'd0);
    tick(1'b1, 4'b0011); chk("multi_ign", 64'(mode), 64'd0);
    tick(1'b1, '0);

    // Mode 2 cool-down of 4000 with a re-pulse in the middle.
    tick(1'b1, 4'b0100); chk("m2_on", 64'(mode), 64'b0100);
    tick(1'b1, 4'b0100);
    chk("m2_cool", 64'(cooling), 64'd1);
    chk("m2_rem", 64'(remain_ms), 64'd4000);
    for (int j = 1; j < 4000; j++) tick(1'b1, (j == 100) ? 4'b0100 : 4'b0000);
    chk("m2_last_mode", 64'(mode), 64'b0100);
    chk("m2_last_rem", 64'(remain_ms), 64'd1);
    tick(1'b1, '0);
    chk("m2_done_mode", 64'(mode), 64'd0);
    chk("m2_done_rem", 64'(remain_ms), 64'd0);

    // Mode 1 cooling aborted by mode 3.
    tick(1'b1, 4'b0010); tick(1'b1, 4'b0010);
    chk("m1_rem", 64'(remain_ms), 64'd2000);
    repeat (500) tick(1'b1, '0);
    chk("m1_rem1500", 64'(remain_ms), 64'd1500);
    tick(1'b1, 4'b1000);
    chk("abort_mode", 64'(mode), 64'b1000);
    chk("abort_cool", 64'(cooling), 64'd0);
    chk("abort_rem", 64'(remain_ms), 64'd0);
    chk("abort_run", 64'(run_ms), 64'd0);

    // Auto-off after 50 cycles: immediate for mode 0, cool-down for mode 1.
    tick(1'b1, 4'b0001);
    repeat (49) tick(1'b1, '0);
    chk("auto0_run49", 64'(run_ms), 64'd49);
    chk("auto0_still", 64'(mode), 64'b0001);
    tick(1'b1, '0);
    chk("auto0_off", 64'(mode), 64'd0);
    tick(1'b1, 4'b0010);
    repeat (49) tick(1'b1, '0);
    chk("auto1_pre", 64'(cooling), 64'd0);
    tick(1'b1, '0);
    chk("auto1_cool", 64'(cooling), 64'd1);
    chk("auto1_rem", 64'(remain_ms), 64'd2000);

    // Master switch drop during cool-down, then a full warm-up again.
    tick(1'b1, 4'b0100); tick(1'b1, 4'b0100);
    repeat (10) tick(1'b1, '0);
    tick(1'b0, '0);
    chk("sw_off_on", 64'(on_st), 64'd0);
    chk("sw_off_mode", 64'(mode), 64'd0);
    chk("sw_off_cool", 64'(cooling), 64'd0);
    tick(1'b1, '0); chk("rewarm_first", 64'(on_st), 64'd1);
    repeat (WU - 1) tick(1'b1, '0);
    chk("rewarm_last", 64'(on_st), 64'd1);
    tick(1'b1, '0); chk("rewarm_ready", 64'(on_st), 64'd2);

    // Asynchronous reset mid-RUN.
    tick(1'b1, 4'b0001);
    repeat (10) tick(1'b1, '0);
    chk("pre_rst_run", 64'(run_ms), 64'd10);
    @(negedge clk_1kHz); #2 rst = 1'b1; #1;
    m_reset();
    chk_model("async_rst");
    tick(1'b1, '0);
    @(negedge clk_1kHz); rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 8000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      rb = '0;
      else if (r < 9) rb = NM'(1) << $urandom_range(0, NM - 1);
      else            rb = NM'($urandom_range(0, 15));
      tick(($urandom_range(0, 599) != 0), rb);
    end
    tick(1'b1, '0);
    finish_run();
  end

endmodule
